// File: rtl/unary_add_ctrl.sv
// Sequencer for a unary pulse-count adder: pulses a binary operand pair into the
// adder, then drains it in read mode and rebuilds the binary sum from dout pulses.
module unary_add_ctrl #(
  parameter int W         = 6,
  parameter int DRAIN_MAX = 2**W + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         err,
  output logic         busy,
  output logic         add_en,
  output logic         add_a,
  output logic         add_b,
  output logic         add_rw,
  input  logic         add_dout,
  input  logic         add_c
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [W-1:0]  ONE_W  = W'(1);
  localparam logic [DW-1:0] ONE_D  = DW'(1);
  localparam logic [DW-1:0] DR_LIM = DW'(DRAIN_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_rem, b_rem, pcnt;
  logic [DW-1:0] dcnt;
  logic [W-1:0]  a_dec, b_dec, pcnt_inc;
  logic [DW-1:0] dcnt_inc;
  logic          accept, drain_end, drain_tmo;

  assign accept    = in_valid && (state == IDLE);
  assign a_dec     = (a_rem != '0) ? a_rem - ONE_W : a_rem;
  assign b_dec     = (b_rem != '0) ? b_rem - ONE_W : b_rem;
  assign pcnt_inc  = add_dout ? pcnt + ONE_W : pcnt;
  assign dcnt_inc  = dcnt + ONE_D;
  // The first drain cycle only covers the adder's read latency, so dout=0 there
  // must not end the phase.
  assign drain_end = (dcnt != '0) && !add_dout;
  assign drain_tmo = (dcnt_inc == DR_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ((op_a == '0) && (op_b == '0)) ? SETTLE : LOAD;
      LOAD:    if ((a_dec == '0) && (b_dec == '0)) state_nxt = SETTLE;
      SETTLE:  state_nxt = DRAIN;
      DRAIN:   if (drain_end || drain_tmo) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    add_en    = 1'b0;
    add_a     = 1'b0;
    add_b     = 1'b0;
    add_rw    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOAD: begin
        add_en = 1'b1;
        add_a  = (a_rem != '0);
        add_b  = (b_rem != '0);
      end
      SETTLE: add_en = 1'b1;
      DRAIN: begin
        add_en = 1'b1;
        add_rw = 1'b1;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Working counters are only meaningful inside an operation; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_rem <= op_a;
      b_rem <= op_b;
    end else if (state == LOAD) begin
      a_rem <= a_dec;
      b_rem <= b_dec;
    end
    if (state == SETTLE) begin
      pcnt <= '0;
      dcnt <= '0;
    end else if (state == DRAIN) begin
      pcnt <= pcnt_inc;
      dcnt <= dcnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        carry <= 1'b0;
        err   <= 1'b0;
      end
      if (state == SETTLE) carry <= add_c;
      if (state == DRAIN) begin
        if (drain_end) begin
          sum <= pcnt_inc;
        end else if (drain_tmo) begin
          sum <= pcnt_inc;
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Bench for unary_add_ctrl: includes a behavioural unary adder and checks results,
// latency and pulse counts against arithmetic expectations.
module tb_unary_add_ctrl;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         carry, err, busy;
  logic         add_en, add_a, add_b, add_rw;
  logic         add_dout, add_c;

  int errors = 0;
  int checks = 0;

  unary_add_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .err(err), .busy(busy),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_rw(add_rw),
    .add_dout(add_dout), .add_c(add_c)
  );

  always #5 clk = ~clk;

  // Behavioural unary adder; 'stuck' forces dout high while reading.
  int   m_count;
  logic m_c, m_dout;
  logic stuck = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_c     <= 1'b0;
      m_dout  <= 1'b0;
    end else if (add_en && !add_rw) begin
      if (m_count + int'(add_a) + int'(add_b) >= 64) m_c <= 1'b1;
      m_count <= (m_count + int'(add_a) + int'(add_b)) % 64;
      m_dout  <= 1'b0;
    end else if (add_en && add_rw) begin
      if (m_count > 0) begin
        m_count <= m_count - 1;
        m_dout  <= 1'b1;
        if (m_count == 1) m_c <= 1'b0;
      end else begin
        m_dout <= stuck;
        m_c    <= 1'b0;
      end
    end else begin
      m_dout <= 1'b0;
    end
  end

  assign add_dout = m_dout;
  assign add_c    = m_c;

  int cnt_a = 0, cnt_b = 0, cnt_d = 0;
  always @(negedge clk) begin
    cnt_a <= cnt_a + int'(add_a);
    cnt_b <= cnt_b + int'(add_b);
    cnt_d <= cnt_d + int'(add_dout);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void ref_op(input int a, input int b,
                                 output int s, output int c, output int lat);
    s   = (a + b) % 64;
    c   = ((a + b) >= 64) ? 1 : 0;
    lat = ((a > b) ? a : b) + s + 4;
  endfunction

  // One full transaction; holds out_ready low 'hold' cycles in DONE while a new
  // in_valid is pending, then handshakes and confirms no same-cycle accept.
  task automatic do_op(input int a, input int b, input int hold,
                       output int r_sum, output int r_carry, output int r_err,
                       output int lat, output int na, output int nb, output int nd);
    int k, a0, b0, d0;
    logic [W-1:0] hs;
    logic hc, he;
    k = 0;
    while (!in_ready && k < 400) begin @(negedge clk); k++; end
    in_valid = 1'b1;
    op_a = W'(a);
    op_b = W'(b);
    a0 = cnt_a; b0 = cnt_b; d0 = cnt_d;
    @(negedge clk);
    lat  = 1;
    op_a = W'($urandom);
    op_b = W'($urandom);
    while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
    r_sum = int'(sum); r_carry = int'(carry); r_err = int'(err);
    na = cnt_a - a0; nb = cnt_b - b0; nd = cnt_d - d0;
    hs = sum; hc = carry; he = err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("done_hold_stable", {out_valid, in_ready, sum, carry, err}, {1'b1, 1'b0, hs, hc, he});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_handshake_idle", {busy, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});
    in_valid = 1'b0;
  endtask

  typedef struct {
    int a; int b; int hold; int s; int c; int lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int gs, gc, ge, gl, na, nb, nd, es, ec, el, ra, rb;
    tbl[0] = '{5, 3, 0, 8, 0, 17};
    tbl[1] = '{40, 30, 0, 6, 1, 50};
    tbl[2] = '{0, 0, 0, 0, 0, 4};
    tbl[3] = '{63, 1, 0, 0, 1, 67};
    tbl[4] = '{2, 2, 0, 4, 0, 10};
    tbl[5] = '{63, 63, 1, 62, 1, 129};
    tbl[6] = '{1, 0, 2, 1, 0, 6};
    tbl[7] = '{0, 7, 0, 7, 0, 18};
    tbl[8] = '{7, 9, 10, 16, 0, 29};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #1;
    chk("reset_outputs",
        {in_ready, out_valid, busy, add_en, add_a, add_b, add_rw, sum, carry, err},
        {1'b1, 14'd0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].hold, gs, gc, ge, gl, na, nb, nd);
      chk($sformatf("vec%0d_sum", i), gs, tbl[i].s);
      chk($sformatf("vec%0d_carry", i), gc, tbl[i].c);
      chk($sformatf("vec%0d_err", i), ge, 0);
      chk($sformatf("vec%0d_latency", i), gl, tbl[i].lat);
      chk($sformatf("vec%0d_a_pulses", i), na, tbl[i].a);
      chk($sformatf("vec%0d_b_pulses", i), nb, tbl[i].b);
      chk($sformatf("vec%0d_dout_pulses", i), nd, tbl[i].s);
    end

    // Reset in the middle of LOAD
    in_valid = 1'b1; op_a = W'(20); op_b = W'(20);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_load_active", {add_en, add_a, add_b, add_rw}, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs",
        {in_ready, out_valid, busy, add_en, add_a, add_b, add_rw, sum, carry, err},
        {1'b1, 14'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 1, 0, gs, gc, ge, gl, na, nb, nd);
    chk("after_reset_sum", gs, 2);
    chk("after_reset_carry", gc, 0);
    chk("after_reset_latency", gl, 7);

    // Drain timeout: adder keeps dout high
    stuck = 1'b1;
    do_op(3, 2, 0, gs, gc, ge, gl, na, nb, nd);
    stuck = 1'b0;
    chk("timeout_err", ge, 1);
    chk("timeout_latency", gl, 71);
    do_op(2, 3, 0, gs, gc, ge, gl, na, nb, nd);
    chk("err_cleared", ge, 0);
    chk("err_cleared_sum", gs, 5);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(63, 0);
      rb = $urandom_range(63, 0);
      ref_op(ra, rb, es, ec, el);
      do_op(ra, rb, $urandom_range(3, 0), gs, gc, ge, gl, na, nb, nd);
      chk($sformatf("rnd%0d_sum(%0d+%0d)", i, ra, rb), gs, es);
      chk($sformatf("rnd%0d_carry", i), gc, ec);
      chk($sformatf("rnd%0d_err", i), ge, 0);
      chk($sformatf("rnd%0d_latency", i), gl, el);
      chk($sformatf("rnd%0d_pulses", i), na + nb, ra + rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
